ysyx_041461_mem_lsu: RTL and testbench
======================================

YSYX_041461_MEM_LSU -- requirements
Module: ysyx_041461_MEM_lsu

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-002 SHALL have rst, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have lsu_valid_in, input, 1, a valid instruction is in the MEM stage.
REQ-004 SHALL have lsu_ctrl_in, input, 4: 0 NOP, 1 LB, 2 LH, 3 LW, 4 LD, 5 LBU, 6 LHU, 7 LWU, 8 SB, 9 SH, 10 SW, 11 SD; 12-15 SHALL be treated as NOP.
REQ-005 SHALL have lsu_addr_in, input, 64, the effective byte address.
REQ-006 SHALL have lsu_wdata_in, input, 64, the store data, right-aligned.
REQ-007 SHALL have mem_req_valid (output, 1), mem_req_ready (input, 1), mem_req_addr (output, 64, 8-byte aligned), mem_req_wen (output, 1), mem_req_wdata (output, 64, lane-shifted) and mem_req_wmask (output, 8).
REQ-008 SHALL have mem_resp_valid, input, 1, and mem_resp_rdata, input, 64; a store completes on mem_resp_valid with the data ignored.
REQ-009 SHALL have lsu_MEM_out (output, 64, extended load result), lsu_stall (output, 1, drives the WB register enable low), lsu_done (output, 1) and lsu_misaligned (output, 1).

Function
REQ-010 SHALL implement the states IDLE, REQ, RESP and DONE.
REQ-011 In IDLE, a memop SHALL latch ctrl, addr and wdata, then move to REQ; a NOP or lsu_valid_in=0 SHALL keep the block in IDLE.
REQ-012 In REQ, mem_req_valid SHALL be 1 and the request fields SHALL be stable; on mem_req_ready=1 the block SHALL move to RESP, otherwise it SHALL hold.
REQ-013 In RESP, mem_resp_valid=1 SHALL capture the result and move to DONE; otherwise the block SHALL wait indefinitely.
REQ-014 DONE SHALL last exactly one cycle, with lsu_done=1 and lsu_stall=0, then return to IDLE.
REQ-015 lsu_stall SHALL be 1 combinationally in IDLE when a memop is presented, and 1 in REQ and RESP; it SHALL be 0 otherwise.
REQ-016 The minimum latency SHALL be 3 stall cycles from memop presentation to DONE, given ready and response each within 1 cycle.
REQ-017 mem_req_addr SHALL be {addr[63:3],3'b0}, and lane offset o SHALL be addr[2:0].
REQ-018 Store wmask SHALL be 0x01, 0x03, 0x0F or 0xFF for B/H/W/D, shifted left by o; wdata SHALL be shifted left by 8*o; loads SHALL drive wmask 0 and wen 0.
REQ-019 Load data SHALL be rdata>>(8*o), truncated to the access size, sign-extended for LB/LH/LW and zero-extended for LBU/LHU/LWU/LD.
REQ-020 lsu_MEM_out SHALL hold its value until the next load completes; stores and NOPs SHALL leave it unchanged.
REQ-021 mem_resp_valid outside RESP SHALL be ignored, and mem_req_ready outside REQ SHALL be ignored.
REQ-022 Inputs SHALL be sampled only in IDLE; changes during REQ, RESP or DONE SHALL have no effect.

Reset
REQ-023 rst=1 SHALL force IDLE, mem_req_valid=0, mem_req_addr=0, mem_req_wen=0, mem_req_wdata=0, mem_req_wmask=0, lsu_MEM_out=0, lsu_done=0 and lsu_misaligned=0, with lsu_stall=0 while rst=1.
REQ-024 Reset during REQ or RESP SHALL abandon the transaction, and a late response after reset SHALL be ignored.

Configuration
REQ-025 With YSYX_041461_LSU_MISALIGN_TRAP_EN defined, a memop in IDLE with addr not naturally aligned for its size SHALL go directly to DONE without a request, with lsu_misaligned=1 for that DONE cycle and lsu_MEM_out unchanged.
REQ-026 Without YSYX_041461_LSU_MISALIGN_TRAP_EN, lsu_misaligned SHALL be tied to 0, and misaligned accesses SHALL be performed with the address low bits cleared to natural alignment.

Verification
REQ-027 LB, addr 0x80000003, ready and response each on first cycle, rdata 0x00000000_80000000 -> stall for 3 cycles, then DONE with lsu_MEM_out=0xFFFFFFFF_FFFFFF80.
REQ-028 SH, addr 0x80000006, wdata 0x1234 -> mem_req_addr=0x80000000, wmask=0xC0, wdata=0x1234_0000_0000_0000, wen=1, and lsu_MEM_out unchanged.
REQ-029 LWU, addr 0x80000004, ready held 0 for 5 cycles then response after 4 further cycles -> request fields stable throughout, stall=1 until DONE, and lsu_MEM_out=rdata[63:32] zero-extended.
REQ-030 rst pulsed during RESP, then mem_resp_valid=1 -> state IDLE, no lsu_done, and lsu_MEM_out=0.
REQ-031 LD, addr 0x80000004 -> with the macro: lsu_misaligned=1 in DONE, mem_req_valid never 1; without the macro: request at 0x80000000.
REQ-032 Back-to-back LD then SD, with a NOP between them -> each memop gives one lsu_done pulse; the NOP causes no stall and no request.

Source files
------------

// File: rtl/ysyx_041461_mem_lsu_if.sv
// Memory-side request/response bus of the MEM-stage load/store unit.
// master: LSU side (drives requests, receives ready and responses).
// slave : memory side.
//   mem_req_valid/ready  request handshake
//   mem_req_addr         8-byte aligned address
//   mem_req_wen          1 = store
//   mem_req_wdata/wmask  lane-shifted store data and byte enables
//   mem_resp_valid/rdata response handshake and read data
interface ysyx_041461_mem_lsu_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/ysyx_041461_mem_lsu.sv
// MEM-stage load/store unit. Accepts one memop in IDLE, issues a single
// aligned 64-bit request, waits for the response and pulses lsu_done for
// one cycle. Stalls the pipeline while the access is outstanding.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   lsu_valid_in      instruction present in MEM
//   lsu_ctrl_in       0 NOP,1 LB,2 LH,3 LW,4 LD,5 LBU,6 LHU,7 LWU,8 SB,9 SH,10 SW,11 SD
//   lsu_addr_in       effective byte address
//   lsu_wdata_in      right-aligned store data
//   mem               memory request/response bus (master side)
//   lsu_MEM_out       extended load result, held until the next load completes
//   lsu_stall         pipeline stall (WB register enable low)
//   lsu_done          one-cycle completion pulse
//   lsu_misaligned    misaligned-access trap flag in the DONE cycle
// Build option: YSYX_041461_LSU_MISALIGN_TRAP_EN turns misaligned memops into
// a request-less DONE with lsu_misaligned=1; otherwise the low address bits are
// cleared to natural alignment and lsu_misaligned is 0.
module ysyx_041461_mem_lsu (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lsu_valid_in,
  input  logic [3:0]                  lsu_ctrl_in,
  input  logic [63:0]                 lsu_addr_in,
  input  logic [63:0]                 lsu_wdata_in,
  ysyx_041461_mem_lsu_if.master       mem,
  output logic [63:0]                 lsu_MEM_out,
  output logic                        lsu_stall,
  output logic                        lsu_done,
  output logic                        lsu_misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic        wen_q, wen_d;
  logic [2:0]  off_q, off_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [63:0] out_q, out_d;
`ifdef YSYX_041461_LSU_MISALIGN_TRAP_EN
  logic        mis_q, mis_d;
  logic        is_mis;
`endif

  // Decode of the presented instruction.
  logic        is_op, is_store, is_signed;
  logic [1:0]  size;
  logic [2:0]  align_keep, off;
  logic [7:0]  byte_mask;
  logic [63:0] data_mask;

  always_comb begin
    is_op     = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size      = 2'd0;
    case (lsu_ctrl_in)
      4'd1:  begin is_op = 1'b1; is_signed = 1'b1; size = 2'd0; end
      4'd2:  begin is_op = 1'b1; is_signed = 1'b1; size = 2'd1; end
      4'd3:  begin is_op = 1'b1; is_signed = 1'b1; size = 2'd2; end
      4'd4:  begin is_op = 1'b1; size = 2'd3; end
      4'd5:  begin is_op = 1'b1; size = 2'd0; end
      4'd6:  begin is_op = 1'b1; size = 2'd1; end
      4'd7:  begin is_op = 1'b1; size = 2'd2; end
      4'd8:  begin is_op = 1'b1; is_store = 1'b1; size = 2'd0; end
      4'd9:  begin is_op = 1'b1; is_store = 1'b1; size = 2'd1; end
      4'd10: begin is_op = 1'b1; is_store = 1'b1; size = 2'd2; end
      4'd11: begin is_op = 1'b1; is_store = 1'b1; size = 2'd3; end
      default: ;
    endcase
    if (!lsu_valid_in) is_op = 1'b0;

    align_keep = 3'b000;
    byte_mask  = 8'hFF;
    data_mask  = '1;
    case (size)
      2'd0: begin align_keep = 3'b111; byte_mask = 8'h01; data_mask = 64'h0000_0000_0000_00FF; end
      2'd1: begin align_keep = 3'b110; byte_mask = 8'h03; data_mask = 64'h0000_0000_0000_FFFF; end
      2'd2: begin align_keep = 3'b100; byte_mask = 8'h0F; data_mask = 64'h0000_0000_FFFF_FFFF; end
      default: ;
    endcase
    // Lane offset rounded down to natural alignment of the access size.
    off = lsu_addr_in[2:0] & align_keep;
`ifdef YSYX_041461_LSU_MISALIGN_TRAP_EN
    is_mis = (lsu_addr_in[2:0] & ~align_keep) != 3'b000;
`endif
  end

  // Load result extraction from the response beat.
  logic [63:0] shifted, load_val;
  always_comb begin
    shifted = mem.mem_resp_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    load_val = sign_q ? {{56{shifted[7]}},  shifted[7:0]}  : {56'd0, shifted[7:0]};
      2'd1:    load_val = sign_q ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
      2'd2:    load_val = sign_q ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    sign_d  = sign_q;
    wen_d   = wen_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    out_d   = out_q;
`ifdef YSYX_041461_LSU_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      IDLE: begin
        if (is_op) begin
          size_d  = size;
          sign_d  = is_signed;
          wen_d   = is_store;
          off_d   = off;
          addr_d  = {lsu_addr_in[63:3], 3'b000};
          wmask_d = is_store ? (byte_mask << off) : 8'h00;
          wdata_d = is_store ? ((lsu_wdata_in & data_mask) << {off, 3'b000}) : '0;
          state_d = REQ;
`ifdef YSYX_041461_LSU_MISALIGN_TRAP_EN
          mis_d   = is_mis;
          if (is_mis) state_d = DONE;
`endif
        end
      end
      REQ:  if (mem.mem_req_ready) state_d = RESP;
      RESP: begin
        if (mem.mem_resp_valid) begin
          state_d = DONE;
          if (!wen_q) out_d = load_val;
        end
      end
      default: begin
        state_d = IDLE;
`ifdef YSYX_041461_LSU_MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      size_q  <= '0;
      sign_q  <= 1'b0;
      wen_q   <= 1'b0;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      out_q   <= '0;
`ifdef YSYX_041461_LSU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      wen_q   <= wen_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      out_q   <= out_d;
`ifdef YSYX_041461_LSU_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // Control outputs are gated by rst so they read 0 for the whole reset cycle.
  assign mem.mem_req_valid = !rst && (state_q == REQ);
  assign mem.mem_req_addr  = addr_q;
  assign mem.mem_req_wen   = wen_q;
  assign mem.mem_req_wdata = wdata_q;
  assign mem.mem_req_wmask = wmask_q;
  assign lsu_MEM_out       = out_q;
  assign lsu_stall         = !rst && ((state_q == IDLE && is_op) || state_q == REQ || state_q == RESP);
  assign lsu_done          = !rst && (state_q == DONE);
`ifdef YSYX_041461_LSU_MISALIGN_TRAP_EN
  assign lsu_misaligned    = !rst && (state_q == DONE) && mis_q;
`else
  assign lsu_misaligned    = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_041461_mem_lsu.sv
module tb_ysyx_041461_mem_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid_in;
  logic [3:0]  lsu_ctrl_in;
  logic [63:0] lsu_addr_in;
  logic [63:0] lsu_wdata_in;
  logic [63:0] lsu_MEM_out;
  logic        lsu_stall, lsu_done, lsu_misaligned;
  int          n_cmp = 0;
  int          n_bad = 0;

  ysyx_041461_mem_lsu_if bus ();

  ysyx_041461_mem_lsu dut (
    .clk(clk), .rst(rst),
    .lsu_valid_in(lsu_valid_in), .lsu_ctrl_in(lsu_ctrl_in),
    .lsu_addr_in(lsu_addr_in), .lsu_wdata_in(lsu_wdata_in),
    .mem(bus),
    .lsu_MEM_out(lsu_MEM_out), .lsu_stall(lsu_stall),
    .lsu_done(lsu_done), .lsu_misaligned(lsu_misaligned)
  );

  always #5 clk = ~clk;

  // {req_valid, wen, stall, done, misaligned}
  logic [4:0] st;
  assign st = {bus.mem_req_valid, bus.mem_req_wen, lsu_stall, lsu_done, lsu_misaligned};

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; lsu_valid_in = 1'b1; lsu_ctrl_in = 4'd3;
    lsu_addr_in = 64'h8000_0000; lsu_wdata_in = '1;
    bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = '1;
    nxt; nxt; #1;
    n_cmp++; if (st !== 5'b00000) begin n_bad++; $display("FAIL reset_status got %b exp %b", st, 5'b00000); end
    n_cmp++; if (bus.mem_req_addr !== 64'h0) begin n_bad++; $display("FAIL reset_addr got %h exp 0", bus.mem_req_addr); end
    n_cmp++; if (bus.mem_req_wdata !== 64'h0 || bus.mem_req_wmask !== 8'h0) begin n_bad++; $display("FAIL reset_wdata got %h/%h exp 0/0", bus.mem_req_wdata, bus.mem_req_wmask); end
    n_cmp++; if (lsu_MEM_out !== 64'h0) begin n_bad++; $display("FAIL reset_out got %h exp 0", lsu_MEM_out); end
    lsu_valid_in = 1'b0; lsu_ctrl_in = 4'd0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    rst = 1'b0;
    nxt;
  endtask

  task automatic test_lb;
    bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 64'h0000_0000_8000_0000;
    lsu_valid_in = 1'b1; lsu_ctrl_in = 4'd1; lsu_addr_in = 64'h8000_0003;
    #1;
    n_cmp++; if (st !== 5'b00100) begin n_bad++; $display("FAIL lb_idle got %b exp %b", st, 5'b00100); end
    nxt; lsu_valid_in = 1'b0; lsu_ctrl_in = 4'd0; #1;
    n_cmp++; if (st !== 5'b10100) begin n_bad++; $display("FAIL lb_req got %b exp %b", st, 5'b10100); end
    n_cmp++; if (bus.mem_req_addr !== 64'h8000_0000 || bus.mem_req_wmask !== 8'h00) begin n_bad++; $display("FAIL lb_req_fields got %h/%h exp 80000000/00", bus.mem_req_addr, bus.mem_req_wmask); end
    nxt; #1;
    n_cmp++; if (st !== 5'b00100) begin n_bad++; $display("FAIL lb_resp got %b exp %b", st, 5'b00100); end
    nxt; #1;
    n_cmp++; if (st !== 5'b00010) begin n_bad++; $display("FAIL lb_done got %b exp %b", st, 5'b00010); end
    n_cmp++; if (lsu_MEM_out !== 64'hFFFF_FFFF_FFFF_FF80) begin n_bad++; $display("FAIL lb_data got %h exp ffffffffffffff80", lsu_MEM_out); end
    nxt; #1;
    n_cmp++; if (st !== 5'b00000 || lsu_MEM_out !== 64'hFFFF_FFFF_FFFF_FF80) begin n_bad++; $display("FAIL lb_after got %b/%h exp 00000/ffffffffffffff80", st, lsu_MEM_out); end
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
  endtask

  task automatic test_sh;
    lsu_valid_in = 1'b1; lsu_ctrl_in = 4'd9; lsu_addr_in = 64'h8000_0006; lsu_wdata_in = 64'h1234;
    nxt;
    lsu_valid_in = 1'b0; lsu_addr_in = 64'h1; lsu_wdata_in = 64'h5555;
    #1;
    n_cmp++; if (st !== 5'b11100) begin n_bad++; $display("FAIL sh_req got %b exp %b", st, 5'b11100); end
    n_cmp++; if (bus.mem_req_addr !== 64'h8000_0000) begin n_bad++; $display("FAIL sh_addr got %h exp 80000000", bus.mem_req_addr); end
    n_cmp++; if (bus.mem_req_wmask !== 8'hC0) begin n_bad++; $display("FAIL sh_wmask got %h exp c0", bus.mem_req_wmask); end
    n_cmp++; if (bus.mem_req_wdata !== 64'h1234_0000_0000_0000) begin n_bad++; $display("FAIL sh_wdata got %h exp 1234000000000000", bus.mem_req_wdata); end
    bus.mem_req_ready = 1'b1;
    nxt;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    #1;
    n_cmp++; if (st !== 5'b01100) begin n_bad++; $display("FAIL sh_resp got %b exp %b", st, 5'b01100); end
    nxt; #1;
    n_cmp++; if (st !== 5'b01010) begin n_bad++; $display("FAIL sh_done got %b exp %b", st, 5'b01010); end
    n_cmp++; if (lsu_MEM_out !== 64'hFFFF_FFFF_FFFF_FF80) begin n_bad++; $display("FAIL sh_out_kept got %h exp ffffffffffffff80", lsu_MEM_out); end
    bus.mem_resp_valid = 1'b0;
    nxt;
  endtask

  task automatic test_lwu;
    lsu_valid_in = 1'b1; lsu_ctrl_in = 4'd7; lsu_addr_in = 64'h8000_0004; lsu_wdata_in = 64'h0;
    nxt;
    // Garbage on the inputs while the access is outstanding.
    lsu_ctrl_in = 4'd11; lsu_addr_in = 64'hDEAD_0000; lsu_wdata_in = '1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (st !== 5'b10100 || bus.mem_req_addr !== 64'h8000_0000 || bus.mem_req_wmask !== 8'h00)
        begin n_bad++; $display("FAIL lwu_hold%0d got %b/%h/%h exp 10100/80000000/00", i, st, bus.mem_req_addr, bus.mem_req_wmask); end
      nxt;
    end
    bus.mem_req_ready = 1'b1;
    #1;
    n_cmp++; if (st !== 5'b10100) begin n_bad++; $display("FAIL lwu_ready got %b exp %b", st, 5'b10100); end
    nxt;
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (st !== 5'b00100) begin n_bad++; $display("FAIL lwu_wait%0d got %b exp %b", i, st, 5'b00100); end
      nxt;
    end
    bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 64'h89AB_CDEF_0123_4567;
    #1;
    n_cmp++; if (st !== 5'b00100) begin n_bad++; $display("FAIL lwu_resp got %b exp %b", st, 5'b00100); end
    nxt;
    bus.mem_resp_valid = 1'b0; lsu_valid_in = 1'b0; lsu_ctrl_in = 4'd0;
    #1;
    n_cmp++; if (st !== 5'b00010) begin n_bad++; $display("FAIL lwu_done got %b exp %b", st, 5'b00010); end
    n_cmp++; if (lsu_MEM_out !== 64'h0000_0000_89AB_CDEF) begin n_bad++; $display("FAIL lwu_data got %h exp 0000000089abcdef", lsu_MEM_out); end
    nxt;
  endtask

  task automatic test_reset_in_resp;
    lsu_valid_in = 1'b1; lsu_ctrl_in = 4'd3; lsu_addr_in = 64'h8000_0000;
    bus.mem_req_ready = 1'b1;
    nxt;
    lsu_valid_in = 1'b0; lsu_ctrl_in = 4'd0;
    nxt;
    bus.mem_req_ready = 1'b0; rst = 1'b1;
    #1;
    n_cmp++; if (st !== 5'b00000) begin n_bad++; $display("FAIL rstresp_during got %b exp %b", st, 5'b00000); end
    nxt;
    rst = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = '1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (st !== 5'b00000 || lsu_MEM_out !== 64'h0) begin n_bad++; $display("FAIL rstresp_late%0d got %b/%h exp 00000/0", i, st, lsu_MEM_out); end
      nxt;
    end
    bus.mem_resp_valid = 1'b0;
  endtask

  task automatic test_misalign;
    bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 64'h1122_3344_5566_7788;
    lsu_valid_in = 1'b1; lsu_ctrl_in = 4'd4; lsu_addr_in = 64'h8000_0004;
    #1;
    n_cmp++; if (st !== 5'b00100) begin n_bad++; $display("FAIL mis_idle got %b exp %b", st, 5'b00100); end
    nxt;
    lsu_valid_in = 1'b0; lsu_ctrl_in = 4'd0;
    #1;
`ifdef YSYX_041461_LSU_MISALIGN_TRAP_EN
    n_cmp++; if (st !== 5'b00011) begin n_bad++; $display("FAIL mis_trap got %b exp %b", st, 5'b00011); end
    n_cmp++; if (lsu_MEM_out !== 64'h0) begin n_bad++; $display("FAIL mis_out_kept got %h exp 0", lsu_MEM_out); end
    nxt; #1;
    n_cmp++; if (st !== 5'b00000) begin n_bad++; $display("FAIL mis_after got %b exp %b", st, 5'b00000); end
`else
    n_cmp++; if (st !== 5'b10100 || bus.mem_req_addr !== 64'h8000_0000) begin n_bad++; $display("FAIL mis_req got %b/%h exp 10100/80000000", st, bus.mem_req_addr); end
    nxt; nxt; #1;
    n_cmp++; if (st !== 5'b00010) begin n_bad++; $display("FAIL mis_done got %b exp %b", st, 5'b00010); end
    n_cmp++; if (lsu_MEM_out !== 64'h1122_3344_5566_7788) begin n_bad++; $display("FAIL mis_data got %h exp 1122334455667788", lsu_MEM_out); end
`endif
    nxt;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    int dones = 0;
    int reqs = 0;
    bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 64'h0F0E_0D0C_0B0A_0908;
    for (int c = 0; c < 10; c++) begin
      lsu_valid_in = 1'b0; lsu_ctrl_in = 4'd0;
      if (c == 0) begin lsu_valid_in = 1'b1; lsu_ctrl_in = 4'd4;  lsu_addr_in = 64'h8000_0010; end
      if (c == 4) begin lsu_valid_in = 1'b1; lsu_ctrl_in = 4'd0; end
      if (c == 5) begin lsu_valid_in = 1'b1; lsu_ctrl_in = 4'd11; lsu_addr_in = 64'h8000_0018; lsu_wdata_in = 64'hDEAD_BEEF_CAFE_F00D; end
      #1;
      if (lsu_done) dones++;
      if (bus.mem_req_valid) reqs++;
      if (c == 3) begin
        n_cmp++; if (lsu_MEM_out !== 64'h0F0E_0D0C_0B0A_0908) begin n_bad++; $display("FAIL b2b_ld_data got %h exp 0f0e0d0c0b0a0908", lsu_MEM_out); end
      end
      if (c == 4) begin
        n_cmp++; if (st !== 5'b00000) begin n_bad++; $display("FAIL b2b_nop got %b exp %b", st, 5'b00000); end
      end
      if (c == 6) begin
        n_cmp++; if (st !== 5'b11100 || bus.mem_req_addr !== 64'h8000_0018 || bus.mem_req_wmask !== 8'hFF || bus.mem_req_wdata !== 64'hDEAD_BEEF_CAFE_F00D)
          begin n_bad++; $display("FAIL b2b_sd_req got %b/%h/%h/%h exp 11100/80000018/ff/deadbeefcafef00d", st, bus.mem_req_addr, bus.mem_req_wmask, bus.mem_req_wdata); end
      end
      if (c == 8) begin
        n_cmp++; if (st !== 5'b01010 || lsu_MEM_out !== 64'h0F0E_0D0C_0B0A_0908) begin n_bad++; $display("FAIL b2b_sd_done got %b/%h exp 01010/0f0e0d0c0b0a0908", st, lsu_MEM_out); end
      end
      nxt;
    end
    n_cmp++; if (dones !== 2) begin n_bad++; $display("FAIL b2b_done_count got %0d exp 2", dones); end
    n_cmp++; if (reqs !== 2) begin n_bad++; $display("FAIL b2b_req_count got %0d exp 2", reqs); end
    // Reserved ctrl code behaves as NOP.
    lsu_valid_in = 1'b1; lsu_ctrl_in = 4'd13;
    #1;
    n_cmp++; if (lsu_stall !== 1'b0) begin n_bad++; $display("FAIL b2b_ctrl13_stall got %b exp 0", lsu_stall); end
    nxt;
    n_cmp++; if (st[4] !== 1'b0 || st[1] !== 1'b0) begin n_bad++; $display("FAIL b2b_ctrl13_idle got %b exp 0xx0x", st); end
    lsu_valid_in = 1'b0; lsu_ctrl_in = 4'd0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_lb;
    test_sh;
    test_lwu;
    test_reset_in_resp;
    test_misalign;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
